// File: rtl/cp0_irq.sv
// cp0_irq: MIPS coprocessor 0 with synchronised external interrupts, Count/Compare timer, EXL guard and PC redirect
//   clk, rst (async, active-low) | mtc0/mfc0/addr/wdata register access | eret, exc/exc_code, pc from the core
//   irq[NUM_IRQ] async level requests | rdata read port | take_exc/exc_addr redirect to the PC mux
module cp0_irq #(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter bit          TIMER_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mtc0,
  input  logic               mfc0,
  input  logic               eret,
  input  logic               exc,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        pc,
  input  logic [4:0]         addr,
  input  logic [31:0]        wdata,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        rdata,
  output logic [31:0]        exc_addr,
  output logic               take_exc
);
  localparam logic [4:0] A_COUNT = 5'd9, A_COMPARE = 5'd11, A_STATUS = 5'd12, A_CAUSE = 5'd13, A_EPC = 5'd14;
  logic [31:0] count, compare, epc, count_inc;
  logic [7:0] im, ip;
  logic [4:0] code;
  logic ie, exl, ti, take_sync, take_irq, take, wr;
  logic [NUM_IRQ-1:0] s1, s2;
  always_comb begin
    ip = '0;
    ip[NUM_IRQ-1:0] = s2;
    ip[7] = ti;
  end
  assign count_inc = count + 32'd1;
  assign take_sync = exc & ~exl;
  assign take_irq  = ie & ~exl & ~exc & |(ip & im);
  assign take      = take_sync | take_irq;
  // a taken exception or an eret squashes the mtc0 of the same instruction
  assign wr        = mtc0 & ~take & ~eret;
  assign take_exc  = rst & (take | eret);
  assign exc_addr  = (rst & eret & ~take) ? epc : EXC_VECTOR;
  always_comb begin
    rdata = !mfc0 ? 32'd0 :
            addr == A_COUNT   ? count :
            addr == A_COMPARE ? compare :
            addr == A_STATUS  ? {16'd0, im, 6'd0, exl, ie} :
            addr == A_CAUSE   ? {16'd0, ip, 1'b0, code, 2'b00} :
            addr == A_EPC     ? epc : 32'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      count <= '0;
      compare <= 32'hFFFF_FFFF;
      ti <= 1'b0;
      epc <= '0;
      code <= '0;
      ie <= 1'b0;
      exl <= 1'b0;
      im <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      count <= !TIMER_EN ? 32'd0 : (wr && addr == A_COUNT) ? wdata : count_inc;
      if (wr && addr == A_COMPARE) compare <= wdata;
      // Compare write clears TI; a Count write replaces the increment, so no match that cycle
      ti <= TIMER_EN && !(wr && addr == A_COMPARE) &&
            (ti || (!(wr && addr == A_COUNT) && count_inc == compare));
      if (take) begin
        epc <= pc;
        code <= take_sync ? exc_code : 5'd0;
        exl <= 1'b1;
      end else if (eret) begin
        exl <= 1'b0;
      end else if (wr && addr == A_STATUS) begin
        ie <= wdata[0];
        exl <= wdata[1];
        im <= wdata[15:8];
      end else if (wr && addr == A_EPC) begin
        epc <= wdata;
      end
    end
  end
endmodule
